// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage. Owns the PC, drives the combinational
//             instruction-memory address and captures {pc, instruction}
//             pairs into a DEPTH-entry prefetch FIFO. The FIFO head is
//             offered to decode over a valid/ready handshake. Execute-stage
//             redirects flush the FIFO and reload the PC.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RESET_PC  PC loaded on reset (word aligned)
//    DEPTH     prefetch FIFO entries (power of 2, >= 2)
//  Build option
//    FETCH_MISALIGN_TRAP_EN - when defined, a misaligned redirect raises a
//    sticky o_misalign flag and halts fetch until the next aligned redirect.
//    When undefined, the o_misalign port is absent and redirect targets are
//    forced to word alignment.
//  Ports
//    clk              in   1   system clock, rising edge
//    rst_n            in   1   asynchronous active-low reset
//    o_imem_addr      out  32  fetch address (= pc)
//    i_imem_instr     in   32  instruction word for o_imem_addr, same cycle
//    i_redirect_valid in   1   taken branch/jump this cycle
//    i_redirect_pc    in   32  redirect target
//    o_dec_valid      out  1   FIFO head valid
//    i_dec_ready      in   1   decode accepts head this cycle
//    o_dec_instr      out  32  head instruction, NOP when empty
//    o_dec_pc         out  32  head PC, zero when empty
//    o_misalign       out  1   misaligned-redirect flag (build option only)
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_instr,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_dec_valid,
  input  logic        i_dec_ready,
  output logic [31:0] o_dec_instr,
  output logic [31:0] o_dec_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        o_misalign
`endif
);

  localparam int              c_PTR_W     = $clog2(DEPTH);
  localparam int              c_CNT_W     = c_PTR_W + 1;
  localparam logic [31:0]     c_NOP       = 32'h0000_0013;
  localparam logic [31:0]     c_PC_STEP   = 32'd4;
  localparam logic [31:0]     c_ALIGN_MSK = 32'hFFFF_FFFC;
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]        r_pc;
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [31:0]        r_mem_pc    [DEPTH];
  logic [31:0]        r_mem_instr [DEPTH];

  logic               w_push;
  logic               w_pop;
  logic               w_halted;
  logic               w_not_full;
  logic [31:0]        w_redirect_target;

  // Low two bits of the target are always dropped; with the trap enabled a
  // misaligned target halts fetch anyway, so the stored PC is irrelevant.
  assign w_redirect_target = i_redirect_pc & c_ALIGN_MSK;

  // --------------------------------------------------------------------------
  // Misaligned-redirect trap
  // --------------------------------------------------------------------------
`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;

  // Sticky until an aligned redirect arrives; halting follows the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else if (i_redirect_valid) begin
      r_misalign <= (i_redirect_pc[1:0] != 2'b00);
    end
  end

  assign w_halted   = r_misalign;
  assign o_misalign = r_misalign;
`else
  assign w_halted   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  assign o_dec_valid = (r_count != '0);
  assign w_not_full  = (r_count != c_DEPTH_CNT);

  // A redirect squashes both sides of the FIFO at that edge.
  assign w_pop  = o_dec_valid & i_dec_ready & ~i_redirect_valid;
  // A full FIFO can still accept when its head leaves in the same cycle.
  assign w_push = ~i_redirect_valid & (w_not_full | w_pop) & ~w_halted;

  // --------------------------------------------------------------------------
  // PC, pointers, occupancy and storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]    <= '0;
        r_mem_instr[i] <= c_NOP;
      end
    end else if (i_redirect_valid) begin
      r_pc     <= w_redirect_target;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem_pc[r_wr_ptr]    <= r_pc;
        r_mem_instr[r_wr_ptr] <= i_imem_instr;
        r_wr_ptr              <= r_wr_ptr + c_PTR_ONE;
        // 32-bit wrap is intentional.
        r_pc                  <= r_pc + c_PC_STEP;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: head of the registered FIFO, idle values when empty
  // --------------------------------------------------------------------------
  assign o_imem_addr = r_pc;
  assign o_dec_instr = o_dec_valid ? r_mem_instr[r_rd_ptr] : c_NOP;
  assign o_dec_pc    = o_dec_valid ? r_mem_pc[r_rd_ptr]    : 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit. A stream-level reference
//             model expects decode to see consecutive word addresses starting
//             at the most recent reset/redirect target, each carrying
//             addr ^ 32'hA5A5_0000 from the modelled instruction memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] c_KEY = 32'hA5A5_0000;
  localparam logic [31:0] c_NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int total = 0;
  int bad   = 0;

  // Expected PC of the next instruction decode will accept.
  logic [31:0] exp_q[$];

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .o_imem_addr     (imem_addr),
    .i_imem_instr    (imem_instr),
    .i_redirect_valid(redirect_valid),
    .i_redirect_pc   (redirect_pc),
    .o_dec_valid     (dec_valid),
    .i_dec_ready     (dec_ready),
    .o_dec_instr     (dec_instr),
    .o_dec_pc        (dec_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .o_misalign      (misalign)
`endif
  );

  assign imem_instr = imem_addr ^ c_KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Any redirect restarts the expected stream at the aligned target.
  task automatic do_redirect(input logic [31:0] tgt, input bit expect_fetch);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    exp_q.delete();
    if (expect_fetch) exp_q.push_back(tgt & 32'hFFFF_FFFC);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: stream order, held head under stall, empty after redirect
  // --------------------------------------------------------------------------
  bit          prev_hold;
  bit          prev_redir;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_n) begin
      prev_hold  <= 1'b0;
      prev_redir <= 1'b0;
    end else begin
      if (prev_redir) chk("empty_after_redirect", {31'd0, dec_valid}, 32'd0);
      if (prev_hold) begin
        chk("stall_hold_valid", {31'd0, dec_valid}, 32'd1);
        chk("stall_hold_pc", dec_pc, prev_pc);
        chk("stall_hold_instr", dec_instr, prev_instr);
      end
      if (dec_valid && dec_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          chk("stream_unexpected", dec_pc, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          chk("stream_pc", dec_pc, e);
          chk("stream_instr", dec_instr, e ^ c_KEY);
          exp_q.push_back(e + 32'd4);
        end
      end
      prev_hold  <= dec_valid && !dec_ready && !redirect_valid;
      prev_redir <= redirect_valid;
      prev_pc    <= dec_pc;
      prev_instr <= dec_instr;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [31:0] t;
    rst_n          = 1'b0;
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    exp_q.push_back(32'h0);
    #12;
    // Reset state
    chk("rst_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_instr", dec_instr, c_NOP);
    chk("rst_pc", dec_pc, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
`endif

    // 1. Release with decode always ready: continuous stream from 0
    tick();
    rst_n     = 1'b1;
    dec_ready = 1'b1;
    chk("t1_valid_release", {31'd0, dec_valid}, 32'd0);
    tick();
    chk("t1_first_valid", {31'd0, dec_valid}, 32'd1);
    chk("t1_first_pc", dec_pc, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t1_no_gap", {31'd0, dec_valid}, 32'd1);
    end

    // 2. Back-pressure from reset: FIFO fills with 0..12, pc parks at 16
    rst_n     = 1'b0;
    dec_ready = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("t2_pc_parked", imem_addr, 32'h10);
    chk("t2_head_pc", dec_pc, 32'h0);
    chk("t2_valid", {31'd0, dec_valid}, 32'd1);
    dec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t2_drain_no_gap", {31'd0, dec_valid}, 32'd1);
    end

    // 3. Full FIFO, redirect to 0x40 with ready high
    dec_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    dec_ready = 1'b1;
    do_redirect(32'h40, 1'b1);
    tick();
    redirect_valid = 1'b0;
    chk("t3_n1_valid", {31'd0, dec_valid}, 32'd0);
    chk("t3_n1_imem_addr", imem_addr, 32'h40);
    tick();
    chk("t3_n2_valid", {31'd0, dec_valid}, 32'd1);
    chk("t3_n2_pc", dec_pc, 32'h40);
    chk("t3_n2_instr", dec_instr, 32'h40 ^ c_KEY);
    for (int i = 0; i < 4; i++) tick();

    // 4. Wrap at the top of the address space
    do_redirect(32'hFFFF_FFFC, 1'b1);
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("t4_top_pc", dec_pc, 32'hFFFF_FFFC);
    tick();
    chk("t4_wrap_valid", {31'd0, dec_valid}, 32'd1);
    chk("t4_wrap_pc", dec_pc, 32'h0);
    chk("t4_no_x", {31'd0, ^{dec_pc, dec_instr, imem_addr} === 1'bx}, 32'd0);

    // 5. Asynchronous reset with three entries buffered
    dec_ready = 1'b0;
    do_redirect(32'h100, 1'b1);
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t5_before_pc", dec_pc, 32'h100);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0);
    #1;
    chk("t5_async_valid", {31'd0, dec_valid}, 32'd0);
    chk("t5_async_instr", dec_instr, c_NOP);
    chk("t5_async_pc", dec_pc, 32'h0);
    chk("t5_async_imem", imem_addr, 32'h0);
    tick();
    rst_n     = 1'b1;
    dec_ready = 1'b1;
    tick();
    chk("t5_restart_pc", dec_pc, 32'h0);
    chk("t5_restart_valid", {31'd0, dec_valid}, 32'd1);

    // 6. Misaligned redirect to 0x22, then aligned redirect to 0x20
`ifdef FETCH_MISALIGN_TRAP_EN
    do_redirect(32'h22, 1'b0);
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t6_misalign_set", {31'd0, misalign}, 32'd1);
      chk("t6_halted_valid", {31'd0, dec_valid}, 32'd0);
      tick();
    end
    do_redirect(32'h20, 1'b1);
    tick();
    redirect_valid = 1'b0;
    chk("t6_misalign_clr", {31'd0, misalign}, 32'd0);
    tick();
    chk("t6_resume_pc", dec_pc, 32'h20);
`else
    do_redirect(32'h22, 1'b1);
    tick();
    redirect_valid = 1'b0;
    chk("t6_aligned_imem", imem_addr, 32'h20);
    tick();
    chk("t6_direct_pc", dec_pc, 32'h20);
    do_redirect(32'h20, 1'b1);
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("t6_resume_pc", dec_pc, 32'h20);
`endif

    // Randomized traffic: stalls and redirects, checked by the monitor
    for (int i = 0; i < 400; i++) begin
      dec_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = 1'b0;
      if ($urandom_range(0, 19) == 0) begin
        t = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
        t = t & 32'hFFFF_FFFC;
`endif
        do_redirect(t, 1'b1);
      end
      tick();
    end
    redirect_valid = 1'b0;
    dec_ready      = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
